mips_cpu_bus: RTL and testbench
===============================

MIPS_CPU_BUS -- requirements
Module: mips_cpu_bus

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning first instruction fetch address after reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port active  output  1  high while executing, low once halted.
REQ-005 SHALL have port register_v0  output  32  continuous copy of GPR $2.
REQ-006 SHALL have port address  output  32  bus byte address, always word-aligned (bits[1:0]=0).
REQ-007 SHALL have port write  output  1  bus write request.
REQ-008 SHALL have port read  output  1  bus read request.
REQ-009 SHALL have port waitrequest  input  1  slave stall; the transfer completes on a rising edge with waitrequest=0.
REQ-010 SHALL have port writedata  output  32  store data.
REQ-011 SHALL have port byteenable  output  4  byte lanes; always 4'b1111.
REQ-012 SHALL have port readdata  input  32  read data, sampled on the completing edge of a read.

Function
REQ-013 SHALL implement 32x32 GPRs, with $0 reading 0 and ignoring writes, plus PC and next-PC registers for branch-delay-slot semantics.
REQ-014 SHALL use states FETCH, EXEC, MEM, HALT.
REQ-015 FETCH: read=1, address=PC; hold while waitrequest=1; on completion latch readdata as the instruction and go to EXEC.
REQ-016 EXEC: decode and execute; write the ALU result to rt/rd; PC<=nextPC and nextPC<=nextPC+4, or for a jump nextPC<=target; LW/SW go to MEM, all others go to FETCH.
REQ-017 MEM: drive address=(rs+signext(imm))&~3; LW sets read=1, and rt<=readdata on completion; SW sets write=1 and writedata=rt; hold while waitrequest=1; then go to FETCH.
REQ-018 Bus outputs SHALL be held stable throughout a stall; read and write SHALL never both be 1.
REQ-019 Supported instructions: LW, SW, ADDIU, ANDI, ORI, XORI, LUI, JR, J.
REQ-020 ANDI, ORI and XORI zero-extend imm16; ADDIU, LW and SW sign-extend it; all arithmetic is modulo 2^32 with no overflow traps.
REQ-021 The instruction after a jump (delay slot) SHALL always execute before the jump target is fetched.
REQ-022 Halt: when the PC about to be fetched equals 32'h00000000, enter HALT instead of FETCH; active=0, read=0 and write=0 from the following cycle, and register_v0 frozen.
REQ-023 Unsupported opcodes and functs SHALL execute as NOP, with PC advancing normally.
REQ-024 Outputs SHALL be decoded from state registers only, with no combinational path from readdata or waitrequest.

Reset
REQ-025 While reset=1 at a rising edge: PC<=RESET_VECTOR, nextPC<=RESET_VECTOR+4, state<=FETCH, all GPRs<=0.
REQ-026 From the first edge with reset=1 onward: active=1, read=1, write=0, address=RESET_VECTOR, byteenable=4'b1111.
REQ-027 Reset asserted mid-instruction or mid-stall SHALL abandon the transfer and restart at RESET_VECTOR.

Configuration
REQ-028 Macro MIPS_CPU_BUS_RTYPE_EN: when defined, SPECIAL functs ADDU, SUBU, AND, OR, XOR and SLT execute as rd<=rs op rt; when undefined, only JR is decoded from SPECIAL and the other functs are NOPs.

Verification
REQ-029 Reset pulse -> on the following negedge, active=1, address=32'hBFC00000, read=1, write=0, byteenable=4'b1111.
REQ-030 Program lw $3,1($0); jr $0; xori $2,$3,0x00F0 with mem[0]=32'h12345678 -> active falls and v0=32'h12345688.
REQ-031 addiu $2,$0,0xFFFF; jr $0; nop -> v0=32'hFFFFFFFF; ori $2,$0,0xFFFF -> v0=32'h0000FFFF.
REQ-032 waitrequest held high 5 cycles on each fetch and load -> address, read and write stay stable throughout, and the REQ-030 result is unchanged.
REQ-033 lui $4,0xABCD; sw $4,8($0); lw $2,8($0); jr $0; nop -> v0=32'hABCD0000, and the store is seen with address=8, write=1, writedata=32'hABCD0000.
REQ-034 addiu $0,$0,5; addu $2,$0,$0 (with RTYPE_EN) -> v0=0; reset mid-stall -> next fetch address is 32'hBFC00000.

Source files
------------

// File: rtl/mips_cpu_bus.sv
// Multi-cycle MIPS-I subset core on a single-port waitrequest bus; `define MIPS_CPU_BUS_RTYPE_EN adds ALU SPECIAL functs.
// Fetch, execute and memory each take one state; bus outputs are registered and held while waitrequest stalls.
module mips_cpu_bus #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        active,
   output logic [31:0] register_v0,
   output logic [31:0] address,
   output logic        write,
   output logic        read,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] FN_JR      = 6'h08;
`ifdef MIPS_CPU_BUS_RTYPE_EN
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;
   localparam logic [5:0] FN_SLT     = 6'h2A;
`endif

   state_t      state;
   logic [31:0] pc, npc, instr;
   logic [31:0] gpr [32];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs_idx, rt_idx;
   logic [15:0] imm;
   logic [31:0] rs_val, rt_val, imm_sext, imm_zext, mem_addr;
   logic        is_lw, is_sw;

   logic        wr_en, is_jump;
   logic [4:0]  wr_idx;
   logic [31:0] wr_val, jump_tgt;

   assign opcode   = instr[31:26];
   assign rs_idx   = instr[25:21];
   assign rt_idx   = instr[20:16];
   assign imm      = instr[15:0];
   assign funct    = instr[5:0];
   assign rs_val   = gpr[rs_idx];
   assign rt_val   = gpr[rt_idx];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};
   assign mem_addr = (rs_val + imm_sext) & 32'hFFFF_FFFC;
   assign is_lw    = (opcode == OP_LW);
   assign is_sw    = (opcode == OP_SW);

   assign register_v0 = gpr[2];
   assign byteenable  = 4'b1111;

`ifdef MIPS_CPU_BUS_RTYPE_EN
   logic [4:0] rd_idx;
   assign rd_idx = instr[15:11];
`endif

   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = rt_idx;
      wr_val   = 32'h0;
      is_jump  = 1'b0;
      jump_tgt = 32'h0;
      case (opcode)
         OP_SPECIAL: begin
            if (funct == FN_JR) begin
               is_jump  = 1'b1;
               jump_tgt = rs_val;
            end
`ifdef MIPS_CPU_BUS_RTYPE_EN
            else begin
               wr_idx = rd_idx;
               wr_en  = 1'b1;
               case (funct)
                  FN_ADDU: wr_val = rs_val + rt_val;
                  FN_SUBU: wr_val = rs_val - rt_val;
                  FN_AND:  wr_val = rs_val & rt_val;
                  FN_OR:   wr_val = rs_val | rt_val;
                  FN_XOR:  wr_val = rs_val ^ rt_val;
                  FN_SLT:  wr_val = {31'h0, $signed(rs_val) < $signed(rt_val)};
                  default: wr_en  = 1'b0;
               endcase
            end
`endif
         end
         // npc already holds the delay-slot address, which supplies the upper PC bits
         OP_J: begin
            is_jump  = 1'b1;
            jump_tgt = {npc[31:28], instr[25:0], 2'b00};
         end
         OP_ADDIU: begin wr_en = 1'b1; wr_val = rs_val + imm_sext;  end
         OP_ANDI:  begin wr_en = 1'b1; wr_val = rs_val & imm_zext;  end
         OP_ORI:   begin wr_en = 1'b1; wr_val = rs_val | imm_zext;  end
         OP_XORI:  begin wr_en = 1'b1; wr_val = rs_val ^ imm_zext;  end
         OP_LUI:   begin wr_en = 1'b1; wr_val = {imm, 16'h0000};    end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FETCH;
         pc        <= RESET_VECTOR;
         npc       <= RESET_VECTOR + 32'd4;
         instr     <= 32'h0;
         address   <= RESET_VECTOR;
         read      <= 1'b1;
         write     <= 1'b0;
         writedata <= 32'h0;
         active    <= 1'b1;
         for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
      end else begin
         case (state)
            FETCH: begin
               if (!waitrequest) begin
                  instr <= readdata;
                  read  <= 1'b0;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (wr_en && wr_idx != 5'd0) gpr[wr_idx] <= wr_val;
               pc  <= npc;
               npc <= is_jump ? jump_tgt : npc + 32'd4;
               if (is_lw || is_sw) begin
                  state     <= MEM;
                  address   <= mem_addr;
                  read      <= is_lw;
                  write     <= is_sw;
                  writedata <= rt_val;
               end else if (npc == 32'h0) begin
                  state  <= HALT;
                  active <= 1'b0;
               end else begin
                  state   <= FETCH;
                  address <= npc;
                  read    <= 1'b1;
               end
            end
            MEM: begin
               if (!waitrequest) begin
                  if (read && rt_idx != 5'd0) gpr[rt_idx] <= readdata;
                  write <= 1'b0;
                  // pc was advanced in EXEC, so it is the next fetch address
                  if (pc == 32'h0) begin
                     state  <= HALT;
                     active <= 1'b0;
                     read   <= 1'b0;
                  end else begin
                     state   <= FETCH;
                     address <= pc;
                     read    <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Bench for mips_cpu_bus: program vectors against a stalling memory model, with a v0/store scoreboard.
module tb_mips_cpu_bus;

   localparam logic [31:0] RV = 32'hBFC00000;
`ifdef MIPS_CPU_BUS_RTYPE_EN
   localparam logic [31:0] SUBU_EXP = 32'd2;
`else
   localparam logic [31:0] SUBU_EXP = 32'd7;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        active, write, read;
   logic        waitrequest = 1'b0;
   logic [31:0] register_v0, address, writedata;
   logic [31:0] readdata = 32'h0;
   logic [3:0]  byteenable;

   always #5 clk = ~clk;

   mips_cpu_bus #(.RESET_VECTOR(RV)) dut (
      .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
      .address(address), .write(write), .read(read), .waitrequest(waitrequest),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
   );

   int checks = 0;
   int errors = 0;
   int stall_cycles = 0;
   int stab_viol = 0, both_viol = 0, align_viol = 0;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] exp_v0_q [$];
   logic [63:0] exp_st_q [$];

   typedef struct {
      logic [7:0][31:0] prog;
      logic [31:0]      d0, d1;
      int               stall;
      logic [31:0]      v0;
      logic             st_vld;
      logic [31:0]      st_addr, st_dat;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] p0, p1, p2, p3, p4, p5, p6,
                               input logic [31:0] d0, d1, input int stall, input logic [31:0] v0,
                               input logic st_vld, input logic [31:0] st_addr, st_dat);
      vec_t v;
      v.prog    = '0;
      v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3;
      v.prog[4] = p4; v.prog[5] = p5; v.prog[6] = p6;
      v.d0 = d0; v.d1 = d1; v.stall = stall; v.v0 = v0;
      v.st_vld = st_vld; v.st_addr = st_addr; v.st_dat = st_dat;
      return v;
   endfunction

   // Memory slave: completion sampled at the edge, new response driven 1 time unit later.
   logic        done, have_prev;
   int          cnt = 0;
   logic [65:0] prev;
   always begin
      @(posedge clk);
      done = 1'b0;
      if (!reset && (read || write) && !waitrequest) begin
         done = 1'b1;
         if (write) begin
            mem[address] = writedata;
            if (exp_st_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL store_unexpected: got addr %h data %h expected no store", address, writedata);
            end else begin
               logic [63:0] e;
               e = exp_st_q.pop_front();
               check("store_addr", address, e[63:32]);
               check("store_data", writedata, e[31:0]);
            end
         end
      end
      #1;
      if (reset || done || !(read || write)) begin
         cnt = 0;
         have_prev = 1'b0;
      end
      if (!(read || write)) begin
         waitrequest = 1'b0;
      end else begin
         if (have_prev && {address, read, write, writedata} !== prev) stab_viol++;
         if (read && write) both_viol++;
         if (address[1:0] != 2'b00) align_viol++;
         prev      = {address, read, write, writedata};
         have_prev = 1'b1;
         waitrequest = (cnt < stall_cycles);
         if (!reset && waitrequest) cnt++;
         readdata = mem.exists(address) ? mem[address] : 32'h0;
      end
   end

   task automatic load_vec(input vec_t v);
      mem.delete();
      for (int i = 0; i < 8; i++) mem[RV + 32'(4 * i)] = v.prog[i];
      mem[32'h0] = v.d0;
      mem[32'h4] = v.d1;
      stall_cycles = v.stall;
      exp_v0_q.push_back(v.v0);
      if (v.st_vld) exp_st_q.push_back({v.st_addr, v.st_dat});
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_active", active, 1'b1);
      check("rst_address", address, RV);
      check("rst_read", read, 1'b1);
      check("rst_write", write, 1'b0);
      check("rst_byteenable", byteenable, 4'b1111);
      reset = 1'b0;
   endtask

   task automatic wait_halt(input int idx);
      int n;
      logic [31:0] e;
      n = 0;
      while (active === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      e = exp_v0_q.pop_front();
      if (active !== 1'b0) begin
         checks++; errors++;
         $display("FAIL v%0d_timeout: got active=%b expected 0 within 3000 cycles", idx, active);
      end else begin
         check($sformatf("v%0d_v0", idx), register_v0, e);
         repeat (3) @(negedge clk);
         check($sformatf("v%0d_halt_read", idx), read, 1'b0);
         check($sformatf("v%0d_halt_write", idx), write, 1'b0);
         check($sformatf("v%0d_v0_frozen", idx), register_v0, e);
      end
   endtask

   initial begin
      int n;
      // lw $3,1($0); jr $0; xori $2,$3,0xF0
      vecs[0]  = mk(32'h8C030001, 32'h00000008, 32'h386200F0, 0, 0, 0, 0,
                    32'h12345678, 0, 0, 32'h12345688, 0, 0, 0);
      vecs[1]  = mk(32'h2402FFFF, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
      vecs[2]  = mk(32'h3402FFFF, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000FFFF, 0, 0, 0);
      vecs[3]  = mk(32'h8C030001, 32'h00000008, 32'h386200F0, 0, 0, 0, 0,
                    32'h12345678, 0, 5, 32'h12345688, 0, 0, 0);
      // lui $4,0xABCD; sw $4,8($0); lw $2,8($0); jr $0; nop
      vecs[4]  = mk(32'h3C04ABCD, 32'hAC040008, 32'h8C020008, 32'h00000008, 0, 0, 0,
                    0, 0, 0, 32'hABCD0000, 1, 32'h8, 32'hABCD0000);
      vecs[5]  = mk(32'h24000005, 32'h00001021, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
      // lw $3,0($0); andi $2,$3,0xFF00
      vecs[6]  = mk(32'h8C030000, 32'h3062FF00, 32'h00000008, 0, 0, 0, 0,
                    32'h12345678, 0, 1, 32'h00005600, 0, 0, 0);
      // addiu $5,$0,16; lw $2,-12($5)
      vecs[7]  = mk(32'h24050010, 32'h8CA2FFF4, 32'h00000008, 0, 0, 0, 0,
                    32'h11111111, 32'hCAFEF00D, 2, 32'hCAFEF00D, 0, 0, 0);
      // j RV+0x10 with delay-slot ori; skipped oris; xori at target
      vecs[8]  = mk(32'h0BF00004, 32'h34020001, 32'h34020022, 32'h34020033,
                    32'h38420100, 32'h00000008, 0, 0, 0, 0, 32'h00000101, 0, 0, 0);
      vecs[9]  = mk(32'h34020055, 32'hFC000000, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0);
      vecs[10] = mk(32'h34020007, 32'h34030005, 32'h00431023, 32'h00000008, 0, 0, 0,
                    0, 0, 0, SUBU_EXP, 0, 0, 0);
      vecs[11] = mk(32'h3C04ABCD, 32'hAC040008, 32'h8C020008, 32'h00000008, 0, 0, 0,
                    0, 0, 3, 32'hABCD0000, 1, 32'h8, 32'hABCD0000);
      // addiu $3,$0,-1; xori $2,$3,0x8000 (zero-extended immediate)
      vecs[12] = mk(32'h2403FFFF, 32'h38628000, 32'h00000008, 0, 0, 0, 0,
                    0, 0, 0, 32'hFFFF7FFF, 0, 0, 0);

      for (int i = 0; i < 13; i++) begin
         load_vec(vecs[i]);
         pulse_reset();
         wait_halt(i);
      end

      // Reset while a load is stalled must abandon it and refetch from the reset vector.
      load_vec(vecs[3]);
      pulse_reset();
      n = 0;
      while (!(read === 1'b1 && address === 32'h0 && waitrequest === 1'b1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL midstall_reach: got no stalled load expected one within 500 cycles");
      end
      reset = 1'b1;
      @(negedge clk);
      check("midstall_address", address, RV);
      check("midstall_read", read, 1'b1);
      check("midstall_write", write, 1'b0);
      check("midstall_active", active, 1'b1);
      reset = 1'b0;
      wait_halt(13);

      check("bus_stable_in_stall", stab_viol, 0);
      check("read_write_exclusive", both_viol, 0);
      check("address_aligned", align_viol, 0);
      check("stores_all_seen", exp_st_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no completion expected finish before 2000000");
      $fatal(1);
   end

endmodule
